// File: rtl/ttt_game_controller_pkg.sv
// Shared types and constants for the tic-tac-toe turn sequencer.
package ttt_game_controller_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_MOVE = 3'd1,
    S_APPLY     = 3'd2,
    S_CHECK     = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  localparam logic [1:0] CELL_EMPTY = 2'd0;
  localparam logic [1:0] CELL_O     = 2'd1;
  localparam logic [1:0] CELL_X     = 2'd2;

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_P1   = 2'd1;
  localparam logic [1:0] WIN_P2   = 2'd2;
  localparam logic [1:0] WIN_DRAW = 2'd3;

  localparam int NUM_CELLS = 9;
  localparam int NUM_LINES = 8;
  localparam int GRID_W    = 2 * NUM_CELLS;

  // Rows, columns, then the two diagonals, as row-major cell indices.
  localparam int LINE_TBL [NUM_LINES][3] = '{
    '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
    '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
    '{0, 4, 8}, '{2, 4, 6}
  };

  // Cell lookup that stays in range for any 4-bit index (out-of-range reads empty).
  function automatic logic [1:0] cell_at(input logic [GRID_W-1:0] g, input logic [3:0] idx);
    cell_at = CELL_EMPTY;
    for (int c = 0; c < NUM_CELLS; c++)
      if (idx == 4'(c)) cell_at = g[2*c +: 2];
  endfunction

endpackage

// File: rtl/ttt_line_detect.sv
// Combinational line/fullness detector over the registered board.
module ttt_line_detect
  import ttt_game_controller_pkg::*;
(
  input  logic [GRID_W-1:0] grid,
  input  logic [1:0]        player,
  output logic              line_hit,
  output logic              board_full
);

  logic [NUM_LINES-1:0] hit;
  logic [NUM_CELLS-1:0] occ;

  // One comparator triple per line; an empty player code never owns a line.
  for (genvar l = 0; l < NUM_LINES; l++) begin : g_line
    assign hit[l] = (player != CELL_EMPTY)
                  && (grid[2*LINE_TBL[l][0] +: 2] == player)
                  && (grid[2*LINE_TBL[l][1] +: 2] == player)
                  && (grid[2*LINE_TBL[l][2] +: 2] == player);
  end

  for (genvar c = 0; c < NUM_CELLS; c++) begin : g_occ
    assign occ[c] = |grid[2*c +: 2];
  end

  assign line_hit   = |hit;
  assign board_full = &occ;

endmodule

// File: rtl/ttt_game_controller.sv
// Turn sequencer: owns the board, validates moves, runs the turn timer, reports win/draw.
module ttt_game_controller
  import ttt_game_controller_pkg::*;
#(
  parameter int unsigned TURN_TIMEOUT = 50_000_000,
  parameter int unsigned TMR_W        = 26
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              move_valid,
  input  logic [3:0]        move_pos,
  output logic              move_ready,
  output logic [GRID_W-1:0] grid,
  output logic [1:0]        cur_player,
  output logic [3:0]        move_count,
  output logic [1:0]        winner,
  output logic              game_over,
  output logic              illegal,
  output logic              timeout
);

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TURN_TIMEOUT - 1);

  state_t            state, state_d;
  logic [GRID_W-1:0] grid_d;
  logic [1:0]        cur_d, win_d;
  logic [3:0]        cnt_d, pos_q, pos_d;
  logic [TMR_W-1:0]  tmr, tmr_d;
  logic              ill_d, to_d;
  logic              line_hit, board_full;
  logic [NUM_CELLS-1:0] cell_we;

  ttt_line_detect u_line_detect (
    .grid       (grid),
    .player     (cur_player),
    .line_hit   (line_hit),
    .board_full (board_full)
  );

  // Per-cell write enable for the latched move position.
  for (genvar c = 0; c < NUM_CELLS; c++) begin : g_we
    assign cell_we[c] = (state == S_APPLY) && (pos_q == 4'(c));
  end

  assign move_ready = (state == S_WAIT_MOVE);
  assign game_over  = (state == S_DONE);

  // Next-state and datapath update; start aborts whatever is in flight.
  always_comb begin
    state_d = state;
    grid_d  = grid;
    cur_d   = cur_player;
    cnt_d   = move_count;
    win_d   = winner;
    pos_d   = pos_q;
    tmr_d   = tmr;
    ill_d   = 1'b0;
    to_d    = 1'b0;
    if (start) begin
      state_d = S_WAIT_MOVE;
      grid_d  = '0;
      cnt_d   = 4'd0;
      win_d   = WIN_NONE;
      cur_d   = CELL_O;
      tmr_d   = '0;
    end else begin
      unique case (state)
        S_IDLE: ;
        S_WAIT_MOVE: begin
          if (move_valid) begin
            // A rejected move leaves the timer where it was.
            if (move_pos > 4'd8 || cell_at(grid, move_pos) != CELL_EMPTY) begin
              ill_d = 1'b1;
            end else begin
              pos_d   = move_pos;
              state_d = S_APPLY;
            end
          end else if (TURN_TIMEOUT != 0) begin
            if (tmr == TMR_LAST) begin
              cur_d = cur_player ^ 2'b11;
              tmr_d = '0;
              to_d  = 1'b1;
            end else begin
              tmr_d = tmr + 1'b1;
            end
          end
        end
        S_APPLY: begin
          for (int c = 0; c < NUM_CELLS; c++)
            if (cell_we[c]) grid_d[2*c +: 2] = cur_player;
          cnt_d   = move_count + 4'd1;
          state_d = S_CHECK;
        end
        S_CHECK: begin
          // Only the mover can have completed a line, so a win on move 9 beats draw.
          if (line_hit) begin
            win_d   = cur_player;
            state_d = S_DONE;
          end else if (board_full) begin
            win_d   = WIN_DRAW;
            state_d = S_DONE;
          end else begin
            cur_d   = cur_player ^ 2'b11;
            tmr_d   = '0;
            state_d = S_WAIT_MOVE;
          end
        end
        S_DONE: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      grid       <= '0;
      cur_player <= 2'b00;
      move_count <= 4'd0;
      winner     <= WIN_NONE;
      pos_q      <= 4'd0;
      tmr        <= '0;
      illegal    <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_d;
      grid       <= grid_d;
      cur_player <= cur_d;
      move_count <= cnt_d;
      winner     <= win_d;
      pos_q      <= pos_d;
      tmr        <= tmr_d;
      illegal    <= ill_d;
      timeout    <= to_d;
    end
  end

endmodule

// File: tb/tb_ttt_game_controller.sv
// Self-checking bench: game-level reference model plus directed literal checks and random play.
module tb_ttt_game_controller;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        move_valid = 1'b0;
  logic [3:0]  move_pos = 4'd0;
  logic        move_ready;
  logic [17:0] grid;
  logic [1:0]  cur_player, winner;
  logic [3:0]  move_count;
  logic        game_over, illegal, timeout;

  int checks = 0;
  int errors = 0;

  ttt_game_controller #(.TURN_TIMEOUT(TO), .TMR_W(4)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .move_valid (move_valid),
    .move_pos   (move_pos),
    .move_ready (move_ready),
    .grid       (grid),
    .cur_player (cur_player),
    .move_count (move_count),
    .winner     (winner),
    .game_over  (game_over),
    .illegal    (illegal),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (game level) ----------------
  localparam int LINES [8][3] = '{
    '{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6}, '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}
  };

  int m_board [9];
  int m_turn, m_cnt, m_win, m_tmr, m_busy, m_pos;
  bit m_over, m_ready, m_ill, m_to;

  // Whichever player holds three in a line, 0 if nobody.
  function automatic int line_owner();
    int own = 0;
    for (int l = 0; l < 8; l++)
      if (m_board[LINES[l][0]] != 0 && m_board[LINES[l][0]] == m_board[LINES[l][1]]
          && m_board[LINES[l][1]] == m_board[LINES[l][2]])
        own = m_board[LINES[l][0]];
    return own;
  endfunction

  function automatic logic [17:0] m_grid();
    logic [17:0] g = '0;
    for (int i = 0; i < 9; i++) g[2*i +: 2] = 2'(m_board[i]);
    return g;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 9; i++) m_board[i] = 0;
      m_turn = 0; m_cnt = 0; m_win = 0; m_tmr = 0; m_busy = 0; m_pos = 0;
      m_over = 0; m_ready = 0; m_ill = 0; m_to = 0;
    end else begin
      m_ill = 0; m_to = 0;
      if (start) begin
        for (int i = 0; i < 9; i++) m_board[i] = 0;
        m_cnt = 0; m_win = 0; m_turn = 1; m_tmr = 0;
        m_ready = 1; m_over = 0; m_busy = 0;
      end else if (m_busy == 2) begin
        m_board[m_pos] = m_turn;          // grid visible one edge after acceptance
        m_cnt++;
        m_busy = 1;
      end else if (m_busy == 1) begin     // outcome visible two edges after acceptance
        m_busy = 0;
        if (line_owner() != 0) begin
          m_win = line_owner(); m_over = 1;
        end else if (m_cnt == 9) begin
          m_win = 3; m_over = 1;
        end else begin
          m_turn = 3 - m_turn; m_tmr = 0; m_ready = 1;
        end
      end else if (m_ready) begin
        if (move_valid) begin
          if (move_pos > 8 || m_board[move_pos] != 0) m_ill = 1;
          else begin m_pos = int'(move_pos); m_busy = 2; m_ready = 0; end
        end else if (m_tmr == TO - 1) begin
          m_turn = 3 - m_turn; m_tmr = 0; m_to = 1;
        end else begin
          m_tmr++;
        end
      end
    end
  end

  task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("move_ready", 18'(move_ready), 18'(m_ready));
    check("grid",       grid,            m_grid());
    check("cur_player", 18'(cur_player), 18'(m_turn));
    check("move_count", 18'(move_count), 18'(m_cnt));
    check("winner",     18'(winner),     18'(m_win));
    check("game_over",  18'(game_over),  18'(m_over));
    check("illegal",    18'(illegal),    18'(m_ill));
    check("timeout",    18'(timeout),    18'(m_to));
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_start();
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic do_move(input int p);
    int n = 0;
    while (!move_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!move_ready) begin
      checks++; errors++;
      $display("FAIL wait_ready: got move_ready=0 expected 1 within 50 cycles");
    end
    move_valid = 1'b1; move_pos = 4'(p);
    @(posedge clk); #1;
    move_valid = 1'b0;
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  localparam int DRAW_SEQ [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};

  initial begin
    // Reset state
    #3;
    check("rst_grid", grid, 18'h0);
    check("rst_cur_player", 18'(cur_player), 18'h0);
    check("rst_outputs", {10'(0), move_ready, game_over, illegal, timeout, winner, 2'(move_count)}, 18'h0);
    @(posedge clk); #2; resetn = 1'b1;
    wait_edges(1);

    // Row 0 win for player 1
    pulse_start();
    do_move(0); do_move(3); do_move(1); do_move(4); do_move(2);
    wait_edges(1);
    check("t1_not_over_yet", 18'(game_over), 18'h0);
    wait_edges(1);
    check("t1_game_over", 18'(game_over), 18'h1);
    check("t1_winner", 18'(winner), 18'h1);
    check("t1_grid", grid, 18'h00295);
    check("t1_move_count", 18'(move_count), 18'h5);

    // Occupied cell, then out-of-range position
    pulse_start();
    do_move(4); do_move(4);
    check("t2_illegal_occ", 18'(illegal), 18'h1);
    check("t2_cur_player", 18'(cur_player), 18'h2);
    check("t2_grid", grid, 18'h00100);
    do_move(9);
    check("t2_illegal_pos", 18'(illegal), 18'h1);
    wait_edges(1);
    check("t2_illegal_pulse", 18'(illegal), 18'h0);

    // Full board without a line
    pulse_start();
    foreach (DRAW_SEQ[i]) do_move(DRAW_SEQ[i]);
    wait_edges(2);
    check("t3_winner_draw", 18'(winner), 18'h3);
    check("t3_move_count", 18'(move_count), 18'h9);
    check("t3_grid", grid, 18'h16A59);
    check("t3_game_over", 18'(game_over), 18'h1);

    // Turn timer expiry, then a move on the expiry cycle
    pulse_start();
    wait_edges(7);
    check("t4_no_timeout_early", 18'(timeout), 18'h0);
    wait_edges(1);
    check("t4_timeout", 18'(timeout), 18'h1);
    check("t4_cur_player", 18'(cur_player), 18'h2);
    pulse_start();
    wait_edges(7);
    do_move(5);
    check("t4_move_beats_timeout", 18'(timeout), 18'h0);
    check("t4_accepted", 18'(move_ready), 18'h0);
    check("t4_credited_p1", 18'(cur_player), 18'h1);
    wait_edges(1);
    check("t4_grid", grid, 18'h00400);

    // Start aborts a move in flight
    pulse_start();
    do_move(0);
    pulse_start();
    check("t5_grid", grid, 18'h0);
    check("t5_move_count", 18'(move_count), 18'h0);
    check("t5_cur_player", 18'(cur_player), 18'h1);
    check("t5_move_ready", 18'(move_ready), 18'h1);

    // Asynchronous reset while checking a move
    pulse_start();
    do_move(0);
    @(posedge clk); #2;
    resetn = 1'b0;
    #1;
    check("t6_grid", grid, 18'h0);
    check("t6_outputs", {8'(0), move_ready, game_over, illegal, timeout, winner, cur_player, move_count}, 18'h0);
    @(posedge clk); #2; resetn = 1'b1;
    wait_edges(1);

    // Random play: busy phase, then sparse moves so the timer fires
    for (int i = 0; i < 4000; i++) begin
      int rate;
      rate = (i < 2000) ? 60 : 12;
      start = ($urandom_range(0, 59) == 0);
      move_valid = ($urandom_range(0, 99) < rate);
      move_pos = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      @(posedge clk); #1;
    end
    start = 1'b0; move_valid = 1'b0;
    wait_edges(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
